// File: rtl/board_write_demux.sv
// Board cell store: single-cell mark writes with occupancy checks, and a one-cell-per-cycle clear sweep.
// Writes take two cycles (accept, then check/commit with a registered response).
module board_write_demux #(
  parameter int NUM_CELLS = 9,
  parameter int SEL_W     = 4,
  parameter int MARK_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [SEL_W-1:0]            wr_sel,
  input  logic [MARK_W-1:0]           wr_mark,
  input  logic                        clr_req,
  output logic                        resp_valid,
  output logic [1:0]                  resp_code,
  output logic                        clr_done,
  output logic [NUM_CELLS*MARK_W-1:0] board,
  output logic [SEL_W:0]              filled_cnt,
  output logic                        board_full
);

  typedef enum logic [1:0] {IDLE, CHECK, CLEAR} state_t;

  localparam logic [1:0]       CODE_OK    = 2'b00;
  localparam logic [1:0]       CODE_RANGE = 2'b01;
  localparam logic [1:0]       CODE_OCC   = 2'b10;
  localparam logic [1:0]       CODE_EMPTY = 2'b11;
  localparam logic [SEL_W:0]   CELLS_W    = (SEL_W+1)'(NUM_CELLS);
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_CELLS-1);

  state_t              state, state_nxt;
  logic [MARK_W-1:0]   cells [NUM_CELLS];
  logic [SEL_W-1:0]    cap_sel;
  logic [MARK_W-1:0]   cap_mark;
  logic [SEL_W-1:0]    sweep;
  logic [MARK_W-1:0]   target_mark;
  logic [MARK_W-1:0]   sweep_mark;
  logic [1:0]          check_code;
  logic                accept;
  logic                do_write;
  logic                sweep_last;

  assign wr_ready   = (state == IDLE) && !clr_req;
  assign accept     = wr_valid && wr_ready;
  assign sweep_last = (sweep == LAST_IDX);
  assign board_full = (filled_cnt == CELLS_W);
  assign do_write   = (state == CHECK) && (check_code == CODE_OK);

  // Cell reads by comparison rather than direct indexing, so out-of-range selects read as empty.
  always_comb begin
    target_mark = '0;
    sweep_mark  = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cap_sel == SEL_W'(i)) target_mark = cells[i];
      if (sweep == SEL_W'(i))   sweep_mark  = cells[i];
    end
  end

  always_comb begin
    check_code = CODE_OK;
    if ({1'b0, cap_sel} >= CELLS_W) check_code = CODE_RANGE;
    else if (cap_mark == '0)        check_code = CODE_EMPTY;
    else if (target_mark != '0)     check_code = CODE_OCC;
  end

  always_comb begin
    for (int i = 0; i < NUM_CELLS; i++) board[i*MARK_W +: MARK_W] = cells[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Clear requests take priority over a write presented in the same IDLE cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
             else if (wr_valid) state_nxt = CHECK;
      CHECK: state_nxt = IDLE;
      CLEAR: if (sweep_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CELLS; i++) cells[i] <= '0;
      filled_cnt <= '0;
      sweep      <= '0;
      cap_sel    <= '0;
      cap_mark   <= '0;
      resp_valid <= 1'b0;
      resp_code  <= CODE_OK;
      clr_done   <= 1'b0;
    end else begin
      resp_valid <= (state == CHECK);
      clr_done   <= (state == CLEAR) && sweep_last;
      if (accept) begin
        cap_sel  <= wr_sel;
        cap_mark <= wr_mark;
      end
      if (state == CHECK) resp_code <= check_code;
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (do_write && cap_sel == SEL_W'(i))
          cells[i] <= cap_mark;
        else if (state == CLEAR && sweep == SEL_W'(i))
          cells[i] <= '0;
      end
      if (do_write)
        filled_cnt <= filled_cnt + (SEL_W+1)'(1);
      else if (state == CLEAR && sweep_mark != '0)
        filled_cnt <= filled_cnt - (SEL_W+1)'(1);
      if (state == CLEAR) sweep <= sweep_last ? '0 : sweep + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_board_write_demux.sv
// Directed bench for board_write_demux: a board model predicts response codes, which are
// queued at the handshake and popped when resp_valid pulses.
module tb_board_write_demux;

  localparam int NUM_CELLS = 9;
  localparam int SEL_W     = 4;
  localparam int MARK_W    = 2;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        wr_valid;
  logic                        wr_ready;
  logic [SEL_W-1:0]            wr_sel;
  logic [MARK_W-1:0]           wr_mark;
  logic                        clr_req;
  logic                        resp_valid;
  logic [1:0]                  resp_code;
  logic                        clr_done;
  logic [NUM_CELLS*MARK_W-1:0] board;
  logic [SEL_W:0]              filled_cnt;
  logic                        board_full;

  int total = 0;
  int bad   = 0;

  logic [1:0]        exp_q [$];
  logic [MARK_W-1:0] model_cells [NUM_CELLS];
  int                model_cnt;

  board_write_demux #(.NUM_CELLS(NUM_CELLS), .SEL_W(SEL_W), .MARK_W(MARK_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_mark(wr_mark), .clr_req(clr_req),
    .resp_valid(resp_valid), .resp_code(resp_code), .clr_done(clr_done),
    .board(board), .filled_cnt(filled_cnt), .board_full(board_full)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] modelCode(input logic [SEL_W-1:0] sel, input logic [MARK_W-1:0] mark);
    if (int'(sel) >= NUM_CELLS)         return 2'b01;
    if (mark == '0)                     return 2'b11;
    if (model_cells[int'(sel)] != '0)   return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [NUM_CELLS*MARK_W-1:0] modelBoard();
    logic [NUM_CELLS*MARK_W-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_CELLS; i++) b[i*MARK_W +: MARK_W] = model_cells[i];
    return b;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NUM_CELLS; i++) model_cells[i] = '0;
    model_cnt = 0;
  endtask

  // Called just after a falling edge; returns after the falling edge of the CHECK cycle.
  task automatic applyStimulus(input logic [SEL_W-1:0] sel, input logic [MARK_W-1:0] mark,
                               input logic clr_in_check);
    logic [1:0] code;
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_mark  = mark;
    #1 checkOutput("wr_ready_idle", 32'(wr_ready), 32'd1);
    code = modelCode(sel, mark);
    exp_q.push_back(code);
    if (code == 2'b00) begin
      model_cells[int'(sel)] = mark;
      model_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    clr_req  = clr_in_check;
    #1 checkOutput("wr_ready_check", 32'(wr_ready), 32'd0);
  endtask

  task automatic waitResponse(input string tag);
    int cycles;
    logic [1:0] exp;
    cycles = 0;
    while (cycles < 4 && !resp_valid) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd1);
    if (resp_valid && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checkOutput({tag, "_code"}, 32'(resp_code), 32'(exp));
    end
    checkOutput({tag, "_board"}, 32'(board), 32'(modelBoard()));
    checkOutput({tag, "_filled"}, 32'(filled_cnt), 32'(model_cnt));
    checkOutput({tag, "_full"}, 32'(board_full), 32'(model_cnt == NUM_CELLS));
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int cycles;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_sel   = '0;
    wr_mark  = '0;
    clr_req  = 1'b0;
    modelReset();

    #12;
    checkOutput("rst_board", 32'(board), 32'd0);
    checkOutput("rst_filled", 32'(filled_cnt), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_code", 32'(resp_code), 32'd0);
    checkOutput("rst_clr_done", 32'(clr_done), 32'd0);
    checkOutput("rst_full", 32'(board_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_wr_ready", 32'(wr_ready), 32'd1);

    $display("[TB] basic writes");
    applyStimulus(4'd4, 2'd1, 1'b0); waitResponse("w4x");
    applyStimulus(4'd4, 2'd2, 1'b0); waitResponse("w4o_occ");
    applyStimulus(4'd9, 2'd1, 1'b0); waitResponse("w9_range");
    applyStimulus(4'd3, 2'd0, 1'b0); waitResponse("w3_empty");
    applyStimulus(4'd15, 2'd3, 1'b0); waitResponse("w15_range");

    $display("[TB] fill board");
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (i != 4) begin
        applyStimulus(SEL_W'(i), (i % 2 == 0) ? 2'd1 : 2'd2, 1'b0);
        waitResponse("fill");
      end
    end
    checkOutput("full_after_fill", 32'(board_full), 32'd1);
    applyStimulus(4'd0, 2'd1, 1'b0); waitResponse("w0_full");

    $display("[TB] clear beats write");
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_sel   = 4'd0;
    wr_mark  = 2'd1;
    #1 checkOutput("clr_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    cycles = 0;
    while (cycles < 20 && !clr_done) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      checkOutput("clr_no_resp", 32'(resp_valid), 32'd0);
      checkOutput("clr_filled", 32'(filled_cnt), 32'(NUM_CELLS - cycles));
    end
    checkOutput("clr_done_seen", 32'(clr_done), 32'd1);
    checkOutput("clr_cycles", 32'(cycles), 32'(NUM_CELLS));
    modelReset();
    checkOutput("clr_board", 32'(board), 32'(modelBoard()));
    checkOutput("clr_full", 32'(board_full), 32'd0);
    @(negedge clk);
    checkOutput("clr_done_pulse_end", 32'(clr_done), 32'd0);
    checkOutput("clr_wr_ready_after", 32'(wr_ready), 32'd1);
    checkOutput("clr_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset during clear");
    applyStimulus(4'd6, 2'd2, 1'b0); waitResponse("w6");
    applyStimulus(4'd8, 2'd1, 1'b0); waitResponse("w8");
    applyStimulus(4'd2, 2'd1, 1'b1); waitResponse("w2_clr_in_check");
    clr_req = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("sweep5_filled", 32'(filled_cnt), 32'd2);
    checkOutput("sweep5_clr_done", 32'(clr_done), 32'd0);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midclr_rst_board", 32'(board), 32'd0);
    checkOutput("midclr_rst_filled", 32'(filled_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("post_rst_clr_done", 32'(clr_done), 32'd0);
      checkOutput("post_rst_resp", 32'(resp_valid), 32'd0);
    end
    checkOutput("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    applyStimulus(4'd0, 2'd2, 1'b0); waitResponse("post_rst_w0");

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
